// File: rtl/n_core_pkg.sv
// Shared n_core definitions: spike index width, neuron count and the
// state encoding of the output spike collector.
package n_core_pkg;

    localparam int SPIKE_W   = 8;
    localparam int N_NEURONS = 32;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FLUSH   = 2'd1,
        PUBLISH = 2'd2
    } out_coll_state_t;

endpackage

// File: rtl/spike_out_collector.sv
// Reader side of the n_core output spike queue. Pops neuron indices,
// rebuilds the per-timestep spike bitmap and, once the core signals end of
// timestep and the queue has drained, publishes map, distinct-spike count and
// step number.
//
// Handshake: the published record (spike_map_o, spike_cnt_o, step_o) is
// offered while map_valid_o is high and is held stable until the consumer
// takes it at the first rising edge with map_valid_o & map_ready_i; map_ready_i
// may be high before map_valid_o. The queue side is first-word fall-through:
// r_data_i is valid while empty_i is low and rd_o pops it at the clock edge.
module spike_out_collector
    import n_core_pkg::*;
#(
    parameter int B      = SPIKE_W,
    parameter int N      = N_NEURONS,
    parameter int CNT_W  = 6,
    parameter int STEP_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  step_done_i,
    input  logic                  empty_i,
    input  logic [B-1:0]          r_data_i,
    output logic                  rd_o,
    output logic [N-1:0]          spike_map_o,
    output logic [CNT_W-1:0]      spike_cnt_o,
    output logic [STEP_W-1:0]     step_o,
    output logic                  map_valid_o,
    input  logic                  map_ready_i,
    output logic                  bad_idx_o,
    output logic                  overrun_o,
    output out_coll_state_t       state_o
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    out_coll_state_t     state;
    out_coll_state_t     state_next;
    logic [N-1:0]        acc;
    logic [CNT_W-1:0]    cnt;
    logic [STEP_W-1:0]   step;
    logic                in_range;
    logic [IDX_W-1:0]    idx;

    // Indices at or above N are reported, never written into the map.
    assign in_range = ({{(32-B){1'b0}}, r_data_i} < 32'(N));
    assign idx      = r_data_i[IDX_W-1:0];
    assign state_o  = state;

    // Pop strobe and next-state selection; PUBLISH stops reads so the core's
    // queue back-pressures while the record is waiting to be taken.
    always_comb begin
        rd_o       = en_i & ~empty_i & (state != PUBLISH);
        state_next = state;
        case (state)
            COLLECT: if (step_done_i) state_next = FLUSH;
            FLUSH:   if (empty_i) state_next = PUBLISH;
            PUBLISH: if (map_valid_o && map_ready_i) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // State, accumulator, counters, sticky flags and published record.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= COLLECT;
            acc         <= '0;
            cnt         <= '0;
            step        <= '0;
            spike_map_o <= '0;
            spike_cnt_o <= '0;
            step_o      <= '0;
            map_valid_o <= 1'b0;
            bad_idx_o   <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            state <= state_next;

            // Pops never happen in PUBLISH, so accumulation and the post-
            // transfer clear below cannot collide.
            if (rd_o) begin
                if (in_range) begin
                    acc[idx] <= 1'b1;
                    if (!acc[idx]) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end else begin
                    bad_idx_o <= 1'b1;
                end
            end

            // A second end-of-step while one is still in flight is dropped.
            if (step_done_i && (state != COLLECT)) begin
                overrun_o <= 1'b1;
            end

            if ((state == FLUSH) && empty_i) begin
                spike_map_o <= acc;
                spike_cnt_o <= cnt;
                step_o      <= step;
                map_valid_o <= 1'b1;
            end

            if ((state == PUBLISH) && map_valid_o && map_ready_i) begin
                map_valid_o <= 1'b0;
                acc         <= '0;
                cnt         <= '0;
                step        <= step + STEP_W'(1);
            end
        end
    end

endmodule
